rr_arbiter9: RTL and testbench
==============================

# rr_arbiter9

Round-robin arbiter that shares one downstream resource among 9 requesters and grants one requester at a time. Priority within a round is descending by index. Winners are selected by the team's existing 9-bit leading-one encoder applied to masked and unmasked request vectors. The block sits between the requesting units and the shared resource, and bounds each tenure with a hold timeout.

## Interface
- HOLD_MAX, 8: maximum consecutive cycles a single grant may be held, legal range 2..15
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req  input  9  level request per requester, bit i = requester i
- rel  input  1  owner releases grant, sampled only in GRANT
- grant  output  9  one-hot grant, all-zero when idle
- grant_valid  output  1  high while any grant is asserted
- grant_idx  output  4  index of current owner, 0..8; 4'd0 when grant_valid=0
- preempt  output  1  one-cycle pulse on the last cycle of a grant ended by timeout

## Operation
- Registered state: `state` (IDLE/GRANT), `ptr[3:0]` (last winner, 0..8), `hold_cnt[3:0]`, and the grant registers.
- Reset values:
  - state=IDLE, ptr=0, hold_cnt=0
  - grant=0, grant_valid=0, grant_idx=0, preempt=0
- Winner selection (combinational, used only in IDLE):
  - mask = (9'b1 << ptr) - 1, i.e. bits strictly below ptr
  - mreq = req & mask
  - winner = leading-one index of mreq if mreq != 0, else leading-one index of req
  - Leading one = highest set bit
  - Encoder output for an all-zero input is never used; `any = |req` gates arbitration.
- IDLE:
  - If any=1: grant <= onehot(winner), grant_idx <= winner, grant_valid <= 1, ptr <= winner, hold_cnt <= 1, state <= GRANT.
  - If any=0: remain in IDLE with outputs 0.
- GRANT: end the grant if rel=1, or req[grant_idx]=0, or hold_cnt == HOLD_MAX.
  - On end: grant, grant_valid and grant_idx are cleared, state <= IDLE, hold_cnt <= 0.
  - Otherwise: hold_cnt <= hold_cnt + 1.
- preempt is combinational: (state==GRANT) & (hold_cnt==HOLD_MAX) & ~rel & req[grant_idx].
- Resulting order: after granting k, the next eligible requesters are k-1..0 (highest first), then wrap to 8..k.
  - With all requests active, the sequence is 8,7,…,0,8,…
  - The first grant after reset goes to the highest requester.
- Simultaneous events:
  - rel and timeout on the same edge count as a release, with no preempt.
  - Owner dropping req together with timeout also gives no preempt.
  - req changes on non-owner bits during GRANT are ignored.
- The 4-bit hold_cnt never exceeds HOLD_MAX and never wraps.

## Timing
- Request-to-grant latency: a request sampled at the IDLE edge k drives grant after edge k, visible in cycle k+1.
- A grant lasts 1..HOLD_MAX cycles; with no release, exactly HOLD_MAX cycles.
- After each grant there is exactly one idle cycle (grant_valid=0) before the next grant, even with pending requests.
- rel is effective on the edge it is sampled high: grant drops in the following cycle.
- Reset mid-operation: all outputs clear immediately on rst assertion without a clock edge. ptr returns to 0, so the first post-reset winner is the highest requester.
- grant, grant_valid and grant_idx are registered; preempt is the only combinational output.

## Structure
- Shared package holds:
  - N_REQ=9 and IDX_W=4
  - the state enum {IDLE, GRANT}
  - the no-grant index constant 4'd0
- Sub-module: two instances of the existing LeadingOne encoder, one on mreq and one on req. A mux selects between them on |mreq.
- Single-process state machine plus a separate combinational winner/mask logic.

## Test plan
- Reset, req=0 for 5 cycles -> grant=0, grant_valid=0. Then req=9'b000100100 -> grant=9'b000100000, grant_idx=5 one cycle later.
- req=9'h1FF held, rel pulsed on each grant's first cycle -> grant_idx sequence 8,7,6,5,4,3,2,1,0,8, separated by single idle cycles.
- HOLD_MAX=4, req=9'b000001000, rel=0 -> grant_idx=3 for exactly 4 cycles, preempt high on the 4th only, 1 idle cycle, then grant_idx=3 again.
- Owner 6 granted, req=9'b011000000, req[6] dropped on cycle 2 -> grant drops next cycle, preempt=0, next grant_idx=7 (wrap, since no requester below 6).
- HOLD_MAX=4, rel=1 on the 4th grant cycle -> grant ends, preempt stays 0.
- rst pulsed mid-grant of owner 2 with req=9'b100000100 -> outputs zero asynchronously. After release of rst, first grant_idx=8.

Source files
------------

// File: rtl/rr_arbiter9_pkg.sv
// Shared types and constants for the 9-requester round-robin arbiter.
// Imported by the top and the leading-one encoder.
package rr_arbiter9_pkg;

    localparam int N_REQ = 9;
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] NO_GRANT_IDX = 4'd0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter9_lead_one.sv
// 9-bit leading-one encoder: index of the highest set bit of vec_i.
// An all-zero input yields 0; callers gate on |vec_i.
module rr_arbiter9_lead_one
    import rr_arbiter9_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o
);

    // NOTE: the default assignment before the loop keeps this combinational
    // block free of inferred latches when no bit is set.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter9.sv
// Round-robin arbiter for 9 requesters, descending priority within a round,
// with a hold timeout that bounds each grant tenure.
module rr_arbiter9
    import rr_arbiter9_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             preempt
);

    localparam logic [IDX_W-1:0] HOLD_MAX_C = IDX_W'(HOLD_MAX);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_valid_q, grant_valid_d;

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] mreq;
    logic [IDX_W-1:0] idx_masked;
    logic [IDX_W-1:0] idx_unmasked;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             owner_req;
    logic             timeout;

    // Requesters strictly below the last winner are served first; otherwise wrap.
    assign mask    = (N_REQ'(1) << ptr_q) - N_REQ'(1);
    assign mreq    = req & mask;
    assign any_req = |req;

    rr_arbiter9_lead_one u_lead_masked (
        .vec_i (mreq),
        .idx_o (idx_masked)
    );

    rr_arbiter9_lead_one u_lead_unmasked (
        .vec_i (req),
        .idx_o (idx_unmasked)
    );

    assign winner = (|mreq) ? idx_masked : idx_unmasked;

    // grant_q is one-hot, so this picks req[grant_idx] without a variable index.
    assign owner_req = |(req & grant_q);
    assign timeout   = (hold_cnt_q == HOLD_MAX_C);

    assign preempt = (state_q == GRANT) & timeout & ~rel & owner_req;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d       = N_REQ'(1) << winner;
                    grant_idx_d   = winner;
                    grant_valid_d = 1'b1;
                    ptr_d         = winner;
                    hold_cnt_d    = 4'd1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (rel || !owner_req || timeout) begin
                    grant_d       = '0;
                    grant_idx_d   = NO_GRANT_IDX;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    state_d       = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= NO_GRANT_IDX;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter9.sv
// Directed self-checking bench for rr_arbiter9 with a 4-cycle hold limit.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_rr_arbiter9;

    logic       clk;
    logic       rst;
    logic [8:0] req;
    logic       rel;
    logic [8:0] grant;
    logic       grant_valid;
    logic [3:0] grant_idx;
    logic       preempt;

    int n_checks;
    int n_pass;

    rr_arbiter9 #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rel         (rel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, 16'(grant), 16'h0);
        check({tag, ".valid"}, 16'(grant_valid), 16'h0);
        check({tag, ".idx"}, 16'(grant_idx), 16'h0);
    endtask

    task automatic check_grant(input string tag, input int idx);
        logic [8:0] oh;
        oh = 9'd1 << idx;
        check({tag, ".grant"}, 16'(grant), 16'(oh));
        check({tag, ".valid"}, 16'(grant_valid), 16'h1);
        check({tag, ".idx"}, 16'(grant_idx), 16'(idx));
    endtask

    int rr_seq[10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 8};

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        #1;
        check_idle("reset");
        check("reset.preempt", 16'(preempt), 16'h0);
        step();
        rst = 1'b0;

        // Idle with no requests, then first grant goes to the highest requester.
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check_idle("no_req");
        req = 9'b000100100;
        step();
        check_grant("first", 5);
        rel = 1'b1;
        step();
        rel = 1'b0;
        check_idle("first_rel");

        // Full rotation with all requests, released on each grant's first cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 9'h1FF;
        for (int k = 0; k < 10; k++) begin
            step();
            check_grant($sformatf("rr%0d", k), rr_seq[k]);
            rel = 1'b1;
            step();
            rel = 1'b0;
            check("rr_gap.valid", 16'(grant_valid), 16'h0);
        end

        // Timeout: single requester 3 holds exactly 4 cycles, preempt on the 4th.
        req = 9'b000001000;
        step();
        check_grant("to.c1", 3);
        check("to.c1.preempt", 16'(preempt), 16'h0);
        step();
        step();
        check_grant("to.c3", 3);
        check("to.c3.preempt", 16'(preempt), 16'h0);
        step();
        check_grant("to.c4", 3);
        check("to.c4.preempt", 16'(preempt), 16'h1);
        step();
        check_idle("to.gap");
        check("to.gap.preempt", 16'(preempt), 16'h0);
        step();
        check_grant("to.regrant", 3);
        req = '0;
        step();
        check_idle("to.drop");

        // Owner drop: grant 7 then 6; 6 drops req on its 2nd cycle, wrap to 7.
        req = 9'b011000000;
        step();
        check_grant("drop.g7", 7);
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        check_grant("drop.c1", 6);
        step();
        req = 9'b010000000;
        #1;
        check("drop.preempt", 16'(preempt), 16'h0);
        step();
        check_idle("drop.end");
        step();
        check_grant("drop.wrap", 7);
        req = '0;
        step();
        check_idle("drop.clear");

        // Release coinciding with timeout counts as a release, no preempt.
        req = 9'b000001000;
        step();
        check_grant("relto.c1", 3);
        step();
        step();
        step();
        rel = 1'b1;
        #1;
        check_grant("relto.c4", 3);
        check("relto.preempt", 16'(preempt), 16'h0);
        step();
        rel = 1'b0;
        check_idle("relto.end");

        // Owner drop coinciding with timeout: no preempt either.
        step();
        check_grant("dropto.c1", 3);
        step();
        step();
        step();
        req = '0;
        #1;
        check("dropto.preempt", 16'(preempt), 16'h0);
        step();
        check_idle("dropto.end");

        // Asynchronous reset mid-grant of owner 2, then restart from the top.
        req = 9'b100000100;
        step();
        check_grant("rst.g2", 2);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst.async");
        check("rst.preempt", 16'(preempt), 16'h0);
        step();
        rst = 1'b0;
        step();
        check_grant("rst.after", 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
